// File: rtl/mcpu_avl_ram_responder.sv
// Block-RAM backed Avalon-MM responder for the 128-bit ltc2mc port; read data returns RD_LATENCY cycles after issue.
// Backpressure: ready drops only while a read burst is issuing (one beat per cycle); writes never stall.
module mcpu_avl_ram_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int RD_LATENCY = 2,
    parameter int MAX_BURST  = 16
) (
    input  logic          clkrst_avl_clk,
    input  logic          clkrst_avl_rst,
    input  logic [24:0]   ltc2mc_avl_addr_0,
    input  logic [15:0]   ltc2mc_avl_be_0,
    input  logic          ltc2mc_avl_burstbegin_0,
    input  logic [4:0]    ltc2mc_avl_size_0,
    input  logic          ltc2mc_avl_read_req_0,
    input  logic          ltc2mc_avl_write_req_0,
    input  logic [127:0]  ltc2mc_avl_wdata_0,
    output logic          ltc2mc_avl_ready_0,
    output logic [127:0]  ltc2mc_avl_rdata_0,
    output logic          ltc2mc_avl_rdata_valid_0,
    output logic          proto_err
);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;
    typedef logic [DEPTH_LOG2-1:0] idx_t;

    localparam logic [4:0] MAX_SZ = 5'(MAX_BURST);

    logic [127:0]          mem [2**DEPTH_LOG2];
    state_t                state_q;
    logic                  ready_q;
    logic                  err_q;
    idx_t                  wr_ptr_q;
    idx_t                  rd_ptr_q;
    logic [4:0]            remain_q;
    logic [RD_LATENCY-1:0] vld_q;
    logic [127:0]          dat_q [RD_LATENCY];

    idx_t       addr_idx;
    logic       size_bad;
    logic [4:0] size_eff;
    logic       wr_first;
    logic       wr_next;
    logic       mem_we;
    idx_t       mem_widx;
    logic       rd_issue;
    logic       unused_addr;

    assign addr_idx    = ltc2mc_avl_addr_0[DEPTH_LOG2-1:0];
    assign unused_addr = &{1'b0, ltc2mc_avl_addr_0[24:DEPTH_LOG2]};

    // Illegal sizes are repaired to the nearest legal length and flagged.
    assign size_bad = (ltc2mc_avl_size_0 == 5'd0) || (ltc2mc_avl_size_0 > MAX_SZ);
    assign size_eff = (ltc2mc_avl_size_0 == 5'd0) ? 5'd1 :
                      (ltc2mc_avl_size_0 > MAX_SZ) ? MAX_SZ : ltc2mc_avl_size_0;

    assign wr_first = ready_q && (state_q == IDLE) && ltc2mc_avl_write_req_0 &&
                      ltc2mc_avl_burstbegin_0 && !ltc2mc_avl_read_req_0;
    assign wr_next  = (state_q == WR_BURST) && ltc2mc_avl_write_req_0;
    assign mem_we   = wr_first || wr_next;
    assign mem_widx = wr_first ? addr_idx : wr_ptr_q;
    assign rd_issue = (state_q == RD_BURST);

    always_ff @(posedge clkrst_avl_clk) begin
        if (mem_we) begin
            for (int i = 0; i < 16; i++) begin
                if (ltc2mc_avl_be_0[i]) mem[mem_widx][8*i +: 8] <= ltc2mc_avl_wdata_0[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clkrst_avl_clk or posedge clkrst_avl_rst) begin
        if (clkrst_avl_rst) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            remain_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (ready_q) begin
                        if (ltc2mc_avl_read_req_0 && ltc2mc_avl_write_req_0) begin
                            err_q <= 1'b1;
                        end else if (ltc2mc_avl_write_req_0) begin
                            if (!ltc2mc_avl_burstbegin_0) begin
                                err_q <= 1'b1;
                            end else begin
                                if (size_bad) err_q <= 1'b1;
                                if (size_eff > 5'd1) begin
                                    wr_ptr_q <= addr_idx + 1'b1;
                                    remain_q <= size_eff - 1'b1;
                                    state_q  <= WR_BURST;
                                end
                            end
                        end else if (ltc2mc_avl_read_req_0) begin
                            if (size_bad) err_q <= 1'b1;
                            rd_ptr_q <= addr_idx;
                            remain_q <= size_eff;
                            state_q  <= RD_BURST;
                            ready_q  <= 1'b0;
                        end
                    end
                end
                WR_BURST: begin
                    if (ltc2mc_avl_read_req_0 || ltc2mc_avl_burstbegin_0) err_q <= 1'b1;
                    if (ltc2mc_avl_write_req_0) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        remain_q <= remain_q - 1'b1;
                        if (remain_q == 5'd1) state_q <= IDLE;
                    end
                end
                RD_BURST: begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    remain_q <= remain_q - 1'b1;
                    if (remain_q == 5'd1) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stage 0 captures the RAM word; each later stage only loads when its input is valid so rdata holds.
    always_ff @(posedge clkrst_avl_clk or posedge clkrst_avl_rst) begin
        if (clkrst_avl_rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= rd_issue;
            if (rd_issue) dat_q[0] <= mem[rd_ptr_q];
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign ltc2mc_avl_ready_0       = ready_q;
    assign ltc2mc_avl_rdata_0       = dat_q[RD_LATENCY-1];
    assign ltc2mc_avl_rdata_valid_0 = vld_q[RD_LATENCY-1];
    assign proto_err                = err_q;

endmodule
